// File: rtl/cic_decimator.sv
// Cascaded integrator-comb decimator with runtime-selectable ratio (1..R_MAX).
// Integrators run at the input rate; decimated tokens ripple through a registered comb chain.
module cic_decimator #(
  parameter int IN_WIDTH   = 12,
  parameter int STAGES     = 3,
  parameter int R_MAX      = 8,
  parameter int DIFF_DELAY = 1,
  parameter int OUT_WIDTH  = 21
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic signed [IN_WIDTH-1:0]  x,
  input  logic                        x_valid,
  input  logic [$clog2(R_MAX):0]      rate,
  output logic signed [OUT_WIDTH-1:0] y,
  output logic                        y_valid
);

  localparam int W  = IN_WIDTH + STAGES * $clog2(R_MAX * DIFF_DELAY);
  localparam int CW = $clog2(R_MAX);
  localparam int RW = CW + 1;

  logic signed [W-1:0] integ      [STAGES];
  logic signed [W-1:0] comb       [STAGES];
  logic signed [W-1:0] dly        [STAGES][DIFF_DELAY];
  logic signed [W-1:0] stage_in   [STAGES];
  logic [STAGES-1:0]   comb_v;
  logic [STAGES-1:0]   stage_in_v;
  logic signed [W-1:0] cap;
  logic                cap_v;
  logic                close;
  logic                close_d;
  logic [CW-1:0]       cnt;
  logic [RW-1:0]       r_eff;
  logic [RW-1:0]       r_cur;
  logic [RW-1:0]       rate_clamped;
  logic                loaded;

  always_comb begin
    if (rate <= RW'(1))
      rate_clamped = RW'(1);
    else if (rate > RW'(R_MAX))
      rate_clamped = RW'(R_MAX);
    else
      rate_clamped = rate;
  end

  // Until the first edge after reset release the live (clamped) rate is the ratio.
  assign r_cur = loaded ? r_eff : rate_clamped;
  assign close = x_valid && (RW'(cnt) == r_cur - RW'(1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt    <= '0;
      r_eff  <= RW'(1);
      loaded <= 1'b0;
    end else begin
      if (!loaded) begin
        loaded <= 1'b1;
        r_eff  <= rate_clamped;
      end
      if (x_valid) begin
        if (close) begin
          cnt   <= '0;
          r_eff <= rate_clamped;
        end else begin
          cnt <= cnt + CW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned k = 0; k < STAGES; k++) integ[k] <= '0;
    end else if (x_valid) begin
      integ[0] <= integ[0] + W'(x);
      for (int unsigned k = 1; k < STAGES; k++) integ[k] <= integ[k] + integ[k-1];
    end
  end

  always_comb begin
    stage_in[0]   = cap;
    stage_in_v[0] = cap_v;
    for (int unsigned k = 1; k < STAGES; k++) begin
      stage_in[k]   = comb[k-1];
      stage_in_v[k] = comb_v[k-1];
    end
  end

  // Capture happens the edge after frame close so the last integrator holds the closing sample's update.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      close_d <= 1'b0;
      cap_v   <= 1'b0;
      cap     <= '0;
      comb_v  <= '0;
      y_valid <= 1'b0;
      y       <= '0;
      for (int unsigned k = 0; k < STAGES; k++) begin
        comb[k] <= '0;
        for (int unsigned j = 0; j < DIFF_DELAY; j++) dly[k][j] <= '0;
      end
    end else begin
      close_d <= close;
      cap_v   <= close_d;
      if (close_d) cap <= integ[STAGES-1];
      comb_v  <= stage_in_v;
      for (int unsigned k = 0; k < STAGES; k++) begin
        if (stage_in_v[k]) begin
          comb[k]   <= stage_in[k] - dly[k][DIFF_DELAY-1];
          dly[k][0] <= stage_in[k];
          for (int unsigned j = 1; j < DIFF_DELAY; j++) dly[k][j] <= dly[k][j-1];
        end
      end
      y_valid <= comb_v[STAGES-1];
      if (comb_v[STAGES-1]) y <= comb[STAGES-1][W-1 -: OUT_WIDTH];
    end
  end

endmodule

// File: tb/tb_cic_decimator.sv
// Randomized and directed bench for cic_decimator against an array-based CIC reference model.
module tb_cic_decimator;

  localparam int W   = 21;
  localparam int OW  = 21;
  localparam int NS  = 3;
  localparam int M   = 1;
  localparam int LAT = NS + 2;

  logic                clk = 1'b0;
  logic                rst;
  logic signed [11:0]  x;
  logic                x_valid;
  logic [3:0]          rate;
  logic signed [20:0]  y;
  logic                y_valid;

  int checks = 0;
  int errors = 0;

  cic_decimator #(
    .IN_WIDTH(12), .STAGES(NS), .R_MAX(8), .DIFF_DELAY(M), .OUT_WIDTH(OW)
  ) dut (
    .clk(clk), .rst(rst), .x(x), .x_valid(x_valid), .rate(rate), .y(y), .y_valid(y_valid)
  );

  always #5 clk = ~clk;

  typedef struct {
    int                 due;
    logic signed [20:0] val;
  } tok_t;

  longint             xs[$];
  longint             vs[$];
  tok_t               pend[$];
  int                 cyc;
  int                 m_cnt;
  int                 m_r;
  bit                 m_loaded;
  logic signed [20:0] model_y;
  logic               model_v;

  function automatic longint wrapw(longint v);
    return v & ((longint'(1) << W) - 1);
  endfunction

  function automatic logic signed [20:0] to_y(longint v);
    longint s;
    s = wrapw(v);
    if (s >= (longint'(1) << (W - 1))) s = s - (longint'(1) << W);
    return 21'(s >>> (W - OW));
  endfunction

  function automatic int clampr(int r);
    if (r <= 1) return 1;
    if (r > 8) return 8;
    return r;
  endfunction

  // Last integrator value after the whole accepted history: cascaded running sums, each stage one sample late.
  function automatic longint integ_last();
    longint a[$];
    longint b[$];
    longint acc;
    a = xs;
    for (int k = 0; k < NS; k++) begin
      b.delete();
      acc = 0;
      for (int n = 0; n < a.size(); n++) begin
        acc = wrapw(acc + ((k == 0) ? a[n] : ((n > 0) ? a[n-1] : 64'sd0)));
        b.push_back(acc);
      end
      a = b;
    end
    return a[$];
  endfunction

  function automatic logic signed [20:0] comb_out();
    longint d[$];
    longint e[$];
    d = vs;
    for (int k = 0; k < NS; k++) begin
      e.delete();
      for (int m = 0; m < d.size(); m++)
        e.push_back(wrapw(d[m] - ((m >= M) ? d[m-M] : 64'sd0)));
      d = e;
    end
    return to_y(d[$]);
  endfunction

  task automatic model_edge(input logic signed [11:0] xi, input logic vi, input logic [3:0] ri);
    int  rc;
    bit  cl;
    cyc++;
    model_v = 1'b0;
    rc = m_loaded ? m_r : clampr(int'(ri));
    cl = 1'b0;
    if (vi) begin
      xs.push_back(longint'(xi));
      if (m_cnt == rc - 1) begin cl = 1'b1; m_cnt = 0; end
      else m_cnt++;
    end
    if (!m_loaded || cl) begin m_r = clampr(int'(ri)); m_loaded = 1'b1; end
    if (cl) begin
      vs.push_back(integ_last());
      pend.push_back('{cyc + LAT, comb_out()});
    end
    if (pend.size() > 0 && pend[0].due == cyc) begin
      model_v = 1'b1;
      model_y = pend[0].val;
      void'(pend.pop_front());
    end
  endtask

  task automatic model_clear();
    xs.delete(); vs.delete(); pend.delete();
    m_cnt = 0; m_loaded = 1'b0; model_y = '0; model_v = 1'b0;
  endtask

  task automatic step(input logic signed [11:0] xi, input logic vi, input logic [3:0] ri);
    @(negedge clk);
    x = xi; x_valid = vi; rate = ri;
    @(posedge clk);
    model_edge(xi, vi, ri);
    #1;
  endtask

  task automatic apply_reset(input logic [3:0] ri);
    @(negedge clk);
    rst = 1'b1; x_valid = 1'b0; x = '0; rate = ri;
    model_clear();
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; x = 12'sd5; x_valid = 1'b1; rate = 4'd8;
    model_clear();
    repeat (3) @(posedge clk);
    #1;
    checks++; if (y !== 21'sd0) begin errors++; $display("FAIL reset_y got %0d exp 0", y); end
    checks++; if (y_valid !== 1'b0) begin errors++; $display("FAIL reset_yv got %b exp 0", y_valid); end
    @(negedge clk);
    x_valid = 1'b0;
    rst = 1'b0;
  endtask

  task automatic test_dc();
    int nv = 0;
    int last = -1;
    apply_reset(4'd8);
    for (int s = 1; s <= 64; s++) begin
      step(12'sd1, 1'b1, 4'd8);
      checks++; if (y_valid !== model_v) begin errors++; $display("FAIL dc_yv step=%0d got %b exp %b", s, y_valid, model_v); end
      checks++; if (y !== model_y) begin errors++; $display("FAIL dc_y step=%0d got %0d exp %0d", s, y, model_y); end
      if (y_valid === 1'b1) begin
        nv++;
        if (nv == 1) begin
          checks++; if (s != 8 + LAT) begin errors++; $display("FAIL dc_first_strobe got %0d exp %0d", s, 8 + LAT); end
        end else begin
          checks++; if (s - last != 8) begin errors++; $display("FAIL dc_interval got %0d exp 8", s - last); end
        end
        if (nv == 4) begin
          checks++; if (y !== 21'sd512) begin errors++; $display("FAIL dc_settle4 got %0d exp 512", y); end
        end
        last = s;
      end
    end
    checks++; if (y !== 21'sd512) begin errors++; $display("FAIL dc_final got %0d exp 512", y); end
  endtask

  task automatic test_rate_change();
    int nv = 0;
    int first = -1;
    int second = -1;
    apply_reset(4'd8);
    for (int s = 1; s <= 52; s++) begin
      step(12'sd1, 1'b1, (s <= 3) ? 4'd8 : 4'd4);
      checks++; if (y_valid !== model_v) begin errors++; $display("FAIL rc_yv step=%0d got %b exp %b", s, y_valid, model_v); end
      checks++; if (y !== model_y) begin errors++; $display("FAIL rc_y step=%0d got %0d exp %0d", s, y, model_y); end
      if (y_valid === 1'b1) begin
        nv++;
        if (nv == 1) first = s;
        if (nv == 2) second = s;
      end
    end
    checks++; if (first != 8 + LAT) begin errors++; $display("FAIL rc_first got %0d exp %0d", first, 8 + LAT); end
    checks++; if (second != 12 + LAT) begin errors++; $display("FAIL rc_second got %0d exp %0d", second, 12 + LAT); end
    checks++; if (y !== 21'sd64) begin errors++; $display("FAIL rc_final got %0d exp 64", y); end
  endtask

  task automatic test_full_scale();
    apply_reset(4'd8);
    for (int s = 1; s <= 56; s++) begin
      step(-12'sd2048, 1'b1, 4'd8);
      checks++; if (y_valid !== model_v) begin errors++; $display("FAIL fsn_yv step=%0d got %b exp %b", s, y_valid, model_v); end
      checks++; if (y !== model_y) begin errors++; $display("FAIL fsn_y step=%0d got %0d exp %0d", s, y, model_y); end
    end
    checks++; if (y !== -21'sd1048576) begin errors++; $display("FAIL fsn_final got %0d exp -1048576", y); end
    apply_reset(4'd8);
    for (int s = 1; s <= 56; s++) begin
      step(12'sd2047, 1'b1, 4'd8);
      checks++; if (y !== model_y) begin errors++; $display("FAIL fsp_y step=%0d got %0d exp %0d", s, y, model_y); end
    end
    checks++; if (y !== 21'sd1048064) begin errors++; $display("FAIL fsp_final got %0d exp 1048064", y); end
  endtask

  task automatic test_stall();
    int nv = 0;
    int last = -1;
    apply_reset(4'd8);
    for (int s = 1; s <= 128; s++) begin
      step(12'sd1, (s % 2) == 1, 4'd8);
      checks++; if (y_valid !== model_v) begin errors++; $display("FAIL stall_yv step=%0d got %b exp %b", s, y_valid, model_v); end
      checks++; if (y !== model_y) begin errors++; $display("FAIL stall_y step=%0d got %0d exp %0d", s, y, model_y); end
      if (y_valid === 1'b1) begin
        nv++;
        if (nv > 1) begin
          checks++; if (s - last != 16) begin errors++; $display("FAIL stall_interval got %0d exp 16", s - last); end
        end
        last = s;
      end
    end
    checks++; if (y !== 21'sd512) begin errors++; $display("FAIL stall_final got %0d exp 512", y); end
  endtask

  task automatic test_reset_midframe();
    int first = -1;
    apply_reset(4'd8);
    for (int s = 1; s <= 21; s++) step(12'sd1, 1'b1, 4'd8);
    checks++; if (y === 21'sd0) begin errors++; $display("FAIL rmf_pre_y got %0d exp nonzero", y); end
    @(negedge clk);
    rst = 1'b1; x_valid = 1'b0;
    model_clear();
    #1;
    checks++; if (y !== 21'sd0) begin errors++; $display("FAIL rmf_y got %0d exp 0", y); end
    checks++; if (y_valid !== 1'b0) begin errors++; $display("FAIL rmf_yv got %b exp 0", y_valid); end
    @(negedge clk);
    rst = 1'b0;
    for (int s = 1; s <= 24; s++) begin
      step(12'sd1, 1'b1, 4'd8);
      checks++; if (y_valid !== model_v) begin errors++; $display("FAIL rmf_post_yv step=%0d got %b exp %b", s, y_valid, model_v); end
      if (y_valid === 1'b1 && first < 0) first = s;
    end
    checks++; if (first != 8 + LAT) begin errors++; $display("FAIL rmf_first got %0d exp %0d", first, 8 + LAT); end
  endtask

  task automatic test_clamp();
    int nv = 0;
    int last = -1;
    apply_reset(4'd0);
    for (int s = 1; s <= 20; s++) begin
      step(12'sd1, 1'b1, 4'd0);
      checks++; if (y_valid !== model_v) begin errors++; $display("FAIL clamp0_yv step=%0d got %b exp %b", s, y_valid, model_v); end
      checks++; if (y !== model_y) begin errors++; $display("FAIL clamp0_y step=%0d got %0d exp %0d", s, y, model_y); end
    end
    checks++; if (y !== 21'sd1) begin errors++; $display("FAIL clamp0_final got %0d exp 1", y); end
    apply_reset(4'd15);
    for (int s = 1; s <= 56; s++) begin
      step(12'sd1, 1'b1, 4'd15);
      checks++; if (y_valid !== model_v) begin errors++; $display("FAIL clamp15_yv step=%0d got %b exp %b", s, y_valid, model_v); end
      if (y_valid === 1'b1) begin
        nv++;
        if (nv > 1) begin
          checks++; if (s - last != 8) begin errors++; $display("FAIL clamp15_interval got %0d exp 8", s - last); end
        end
        last = s;
      end
    end
    checks++; if (y !== 21'sd512) begin errors++; $display("FAIL clamp15_final got %0d exp 512", y); end
  endtask

  task automatic test_back_to_back();
    int nv = 0;
    logic signed [11:0] xi;
    apply_reset(4'd1);
    for (int s = 1; s <= 30; s++) begin
      xi = 12'($urandom_range(4095));
      step(xi, 1'b1, 4'd1);
      checks++; if (y_valid !== model_v) begin errors++; $display("FAIL b2b_yv step=%0d got %b exp %b", s, y_valid, model_v); end
      checks++; if (y !== model_y) begin errors++; $display("FAIL b2b_y step=%0d got %0d exp %0d", s, y, model_y); end
      if (y_valid === 1'b1) nv++;
    end
    checks++; if (nv != 30 - LAT) begin errors++; $display("FAIL b2b_count got %0d exp %0d", nv, 30 - LAT); end
  endtask

  task automatic test_random();
    logic [3:0]         ri;
    logic signed [11:0] xi;
    logic               vi;
    ri = 4'($urandom_range(15));
    apply_reset(ri);
    for (int s = 1; s <= 400; s++) begin
      if (s % 37 == 0) ri = 4'($urandom_range(15));
      xi = 12'($urandom_range(4095));
      vi = ($urandom_range(3) != 0);
      step(xi, vi, ri);
      checks++; if (y_valid !== model_v) begin errors++; $display("FAIL rand_yv step=%0d got %b exp %b", s, y_valid, model_v); end
      checks++; if (y !== model_y) begin errors++; $display("FAIL rand_y step=%0d got %0d exp %0d", s, y, model_y); end
    end
  endtask

  initial begin
    cyc = 0;
    test_reset();
    test_dc();
    test_rate_change();
    test_full_scale();
    test_stall();
    test_reset_midframe();
    test_clamp();
    test_back_to_back();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
